// File: rtl/calc_seq_ctrl.sv
// ---------------------------------------------------------------------------
// calc_seq_ctrl : keypad calculator sequencer
//
// Collects two decimal operands (0..OP_MAX) and an operator from a keypad key
// stream, runs the arithmetic and holds the result for the display stage.
// ADD/SUB complete in one S_CALC cycle; MUL runs a shift-add over OPW cycles.
//
// Optional feature (macro CALC_CHAIN_EN): an operator key in S_SHOW chains a
// non-negative, in-range result into operand A of the next calculation.
// Without the macro, operator keys in S_SHOW are ignored.
//
// Ports:
//   clk, rst    clock, asynchronous active-high reset
//   key_valid   key_code is valid this cycle
//   key_code    0-9 digit, 10 ADD, 11 SUB, 12 MUL, 13 ENTER, 14 CLEAR, 15 no-op
//   operand_a   operand A            operand_b   operand B
//   op          0 ADD, 1 SUB, 2 MUL
//   result      magnitude of the last result (2*OPW bits)
//   result_neg  result is negative (SUB only)
//   state       0 S_OPA, 1 S_OPB, 2 S_CALC, 3 S_SHOW
//   busy        high while in S_CALC
//   done        one-cycle pulse on the first S_SHOW cycle
// ---------------------------------------------------------------------------
module calc_seq_ctrl #(
  parameter int OPW    = 7,
  parameter int OP_MAX = 99
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             key_valid,
  input  logic [3:0]       key_code,
  output logic [OPW-1:0]   operand_a,
  output logic [OPW-1:0]   operand_b,
  output logic [1:0]       op,
  output logic [2*OPW-1:0] result,
  output logic             result_neg,
  output logic [1:0]       state,
  output logic             busy,
  output logic             done
);

  localparam int RW = 2 * OPW;
  localparam int CW = (OPW > 1) ? $clog2(OPW) : 1;

`ifdef CALC_CHAIN_EN
  localparam logic CHAIN_EN = 1'b1;
`else
  localparam logic CHAIN_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_OPA  = 2'd0,
    S_OPB  = 2'd1,
    S_CALC = 2'd2,
    S_SHOW = 2'd3
  } state_t;

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_MUL = 2'd2;

  state_t        st, nxt;
  logic [CW-1:0] cnt;

  logic is_digit, is_oper, is_enter, is_clear;
  logic mul_last, chain_ok;
  logic [1:0]     key_op;
  logic [OPW-1:0] digit;

  assign is_digit = key_valid && (key_code <= 4'd9);
  assign is_oper  = key_valid && (key_code >= 4'd10) && (key_code <= 4'd12);
  assign is_enter = key_valid && (key_code == 4'd13);
  assign is_clear = key_valid && (key_code == 4'd14);
  assign key_op   = 2'(key_code - 4'd10);
  assign digit    = OPW'(key_code);
  assign mul_last = (cnt == CW'(OPW - 1));
  assign chain_ok = CHAIN_EN && is_oper && !result_neg && (result <= RW'(OP_MAX));

  assign state = st;
  assign busy  = (st == S_CALC);

  // Decimal shift-in keeping only the last two digits.
  function automatic logic [OPW-1:0] shift_in(input logic [OPW-1:0] x,
                                              input logic [OPW-1:0] d);
    logic [OPW-1:0] lo;
    lo = x % OPW'(10);
    return lo * OPW'(10) + d;
  endfunction

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) st <= S_OPA;
    else     st <= nxt;
  end

  // NOTE: nxt gets its default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    nxt = st;
    case (st)
      S_OPA:  if (is_oper) nxt = S_OPB;
      S_OPB: begin
        if (is_enter)      nxt = S_CALC;
        else if (is_clear) nxt = S_OPA;
      end
      S_CALC: if (op != OP_MUL || mul_last) nxt = S_SHOW;
      S_SHOW: begin
        if (is_digit || is_clear) nxt = S_OPA;
        else if (chain_ok)        nxt = S_OPB;
      end
      default: nxt = S_OPA;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      operand_a  <= '0;
      operand_b  <= '0;
      op         <= OP_ADD;
      result     <= '0;
      result_neg <= 1'b0;
      cnt        <= '0;
      done       <= 1'b0;
    end else begin
      done <= (st == S_CALC) && (nxt == S_SHOW);
      case (st)
        S_OPA: begin
          if (is_digit) operand_a <= shift_in(operand_a, digit);
          else if (is_oper) begin
            op        <= key_op;
            operand_b <= '0;
          end else if (is_clear) begin
            operand_a <= '0;
            op        <= OP_ADD;
          end
        end
        S_OPB: begin
          if (is_digit)     operand_b <= shift_in(operand_b, digit);
          else if (is_oper) op <= key_op;
          else if (is_enter) begin
            cnt    <= '0;
            result <= '0;
          end else if (is_clear) begin
            operand_a  <= '0;
            operand_b  <= '0;
            op         <= OP_ADD;
            result     <= '0;
            result_neg <= 1'b0;
          end
        end
        S_CALC: begin
          // Keys are dropped here; only the arithmetic advances.
          case (op)
            OP_SUB: begin
              if (operand_a >= operand_b) begin
                result     <= RW'(operand_a - operand_b);
                result_neg <= 1'b0;
              end else begin
                result     <= RW'(operand_b - operand_a);
                result_neg <= 1'b1;
              end
            end
            OP_MUL: begin
              // One partial product per cycle, LSB of operand_b first.
              if (operand_b[cnt]) result <= result + (RW'(operand_a) << cnt);
              cnt <= cnt + CW'(1);
            end
            default: result <= RW'(operand_a) + RW'(operand_b);
          endcase
        end
        S_SHOW: begin
          if (is_digit) begin
            operand_a  <= digit;
            operand_b  <= '0;
            result     <= '0;
            result_neg <= 1'b0;
          end else if (is_clear) begin
            operand_a  <= '0;
            operand_b  <= '0;
            op         <= OP_ADD;
            result     <= '0;
            result_neg <= 1'b0;
            cnt        <= '0;
          end else if (chain_ok) begin
            operand_a  <= result[OPW-1:0];
            op         <= key_op;
            operand_b  <= '0;
            result_neg <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_calc_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_calc_seq_ctrl : self-checking bench for calc_seq_ctrl.
// Directed scenarios plus a randomized key stream compared against a
// key-level behavioural model (plain arithmetic, cycle-count latency).
// ---------------------------------------------------------------------------
module tb_calc_seq_ctrl;
  localparam int OPW = 7;
  localparam int RW  = 2 * OPW;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            key_valid = 1'b0;
  logic [3:0]      key_code = 4'd0;
  logic [OPW-1:0]  operand_a, operand_b;
  logic [1:0]      op, state;
  logic [RW-1:0]   result;
  logic            result_neg, busy, done;

  int n_checks = 0;
  int n_fail   = 0;

  calc_seq_ctrl #(.OPW(OPW), .OP_MAX(99)) dut (
    .clk(clk), .rst(rst), .key_valid(key_valid), .key_code(key_code),
    .operand_a(operand_a), .operand_b(operand_b), .op(op), .result(result),
    .result_neg(result_neg), .state(state), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // One clock cycle with optional key; outputs settle 1 time unit after the edge.
  task automatic tick(input logic v, input logic [3:0] c);
    @(negedge clk);
    key_valid = v;
    key_code  = c;
    @(posedge clk);
    #1;
    key_valid = 1'b0;
  endtask

  task automatic key(input logic [3:0] c);
    tick(1'b1, c);
  endtask

  task automatic idle();
    tick(1'b0, 4'd0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #12;
    n_checks++;
    if ({operand_a, operand_b, op, result, result_neg, state, busy, done} !== '0) begin
      n_fail++;
      $display("FAIL reset_state: a=%0d b=%0d op=%0d res=%0d neg=%0b st=%0d busy=%0b done=%0b, required all 0",
               operand_a, operand_b, op, result, result_neg, state, busy, done);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_add();
    int k;
    key(4); key(2); key(10); key(1); key(7); key(13);
    n_checks++;
    if (state !== 2'd2 || busy !== 1'b1 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL add_enter: state=%0d busy=%0b done=%0b, required 2 1 0", state, busy, done);
    end
    k = 0;
    while (state == 2'd2 && k < 20) begin idle(); k++; end
    n_checks++;
    if (k !== 1) begin
      n_fail++;
      $display("FAIL add_latency: calc cycles=%0d, required 1", k);
    end
    n_checks++;
    if (done !== 1'b1 || result !== RW'(59) || result_neg !== 1'b0 ||
        operand_a !== OPW'(42) || operand_b !== OPW'(17) || state !== 2'd3) begin
      n_fail++;
      $display("FAIL add_result: done=%0b res=%0d neg=%0b a=%0d b=%0d st=%0d, required 1 59 0 42 17 3",
               done, result, result_neg, operand_a, operand_b, state);
    end
    idle();
    n_checks++;
    if (done !== 1'b0 || result !== RW'(59) || state !== 2'd3) begin
      n_fail++;
      $display("FAIL add_hold: done=%0b res=%0d st=%0d, required 0 59 3", done, result, state);
    end
  endtask

  task automatic test_clear_opa();
    key(14);
    n_checks++;
    if (state !== 2'd0 || result !== '0 || operand_a !== '0 || operand_b !== '0 || op !== 2'd0) begin
      n_fail++;
      $display("FAIL show_clear: st=%0d res=%0d a=%0d b=%0d op=%0d, required all 0",
               state, result, operand_a, operand_b, op);
    end
    key(1); key(2); key(3);
    n_checks++;
    if (operand_a !== OPW'(23)) begin
      n_fail++;
      $display("FAIL digit_shift: a=%0d, required 23", operand_a);
    end
    key(14);
    n_checks++;
    if (operand_a !== '0 || state !== 2'd0) begin
      n_fail++;
      $display("FAIL opa_clear: a=%0d st=%0d, required 0 0", operand_a, state);
    end
  endtask

  task automatic test_sub();
    key(5); key(11); key(1); key(2); key(13); idle();
    n_checks++;
    if (result !== RW'(7) || result_neg !== 1'b1 || done !== 1'b1 || state !== 2'd3) begin
      n_fail++;
      $display("FAIL sub_result: res=%0d neg=%0b done=%0b st=%0d, required 7 1 1 3",
               result, result_neg, done, state);
    end
    key(8);
    n_checks++;
    if (operand_a !== OPW'(8) || operand_b !== '0 || result !== '0 ||
        result_neg !== 1'b0 || state !== 2'd0) begin
      n_fail++;
      $display("FAIL show_digit: a=%0d b=%0d res=%0d neg=%0b st=%0d, required 8 0 0 0 0",
               operand_a, operand_b, result, result_neg, state);
    end
  endtask

  task automatic test_mul_busy();
    int k;
    key(14);
    key(9); key(9); key(12); key(9); key(9); key(13);
    k = 0;
    while (busy === 1'b1 && k < 20) begin
      n_checks++;
      if (state !== 2'd2 || done !== 1'b0) begin
        n_fail++;
        $display("FAIL mul_busy_state: st=%0d done=%0b at calc cycle %0d, required 2 0", state, done, k);
      end
      key((k % 2 == 0) ? 4'd14 : 4'd5);
      k++;
    end
    n_checks++;
    if (k !== OPW) begin
      n_fail++;
      $display("FAIL mul_busy_len: busy cycles=%0d, required %0d", k, OPW);
    end
    n_checks++;
    if (result !== RW'(9801) || done !== 1'b1 || state !== 2'd3 ||
        operand_a !== OPW'(99) || operand_b !== OPW'(99) || op !== 2'd2) begin
      n_fail++;
      $display("FAIL mul_result: res=%0d done=%0b st=%0d a=%0d b=%0d op=%0d, required 9801 1 3 99 99 2",
               result, done, state, operand_a, operand_b, op);
    end
  endtask

  task automatic test_reset_mid_mul();
    key(14);
    key(1); key(2); key(12); key(3); key(4); key(13);
    idle(); idle(); idle();
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({operand_a, operand_b, op, result, result_neg, state, busy, done} !== '0) begin
      n_fail++;
      $display("FAIL async_reset: a=%0d b=%0d op=%0d res=%0d st=%0d busy=%0b, required all 0",
               operand_a, operand_b, op, result, state, busy);
    end
    @(negedge clk);
    rst = 1'b0;
    key(2); key(10); key(3); key(13); idle();
    n_checks++;
    if (result !== RW'(5) || state !== 2'd3) begin
      n_fail++;
      $display("FAIL after_reset_add: res=%0d st=%0d, required 5 3", result, state);
    end
  endtask

  task automatic test_chain();
    int k;
    key(14);
    key(3); key(10); key(4); key(13); idle();
    n_checks++;
    if (result !== RW'(7)) begin
      n_fail++;
      $display("FAIL chain_first: res=%0d, required 7", result);
    end
    key(12);
`ifdef CALC_CHAIN_EN
    n_checks++;
    if (state !== 2'd1 || operand_a !== OPW'(7) || op !== 2'd2 || operand_b !== '0) begin
      n_fail++;
      $display("FAIL chain_op: st=%0d a=%0d op=%0d b=%0d, required 1 7 2 0", state, operand_a, op, operand_b);
    end
    key(5); key(13);
    k = 0;
    while (state == 2'd2 && k < 20) begin idle(); k++; end
    n_checks++;
    if (result !== RW'(35) || k !== OPW) begin
      n_fail++;
      $display("FAIL chain_result: res=%0d cycles=%0d, required 35 %0d", result, k, OPW);
    end
`else
    k = 0;
    n_checks++;
    if (state !== 2'd3 || result !== RW'(7) || op !== 2'd0) begin
      n_fail++;
      $display("FAIL nochain_op: st=%0d res=%0d op=%0d, required 3 7 0", state, result, op);
    end
    key(5);
    n_checks++;
    if (state !== 2'd0 || operand_a !== OPW'(5) || result !== '0) begin
      n_fail++;
      $display("FAIL nochain_digit: st=%0d a=%0d res=%0d, required 0 5 0", state, operand_a, result);
    end
    key(13);
    n_checks++;
    if (state !== 2'd0 || k !== 0) begin
      n_fail++;
      $display("FAIL nochain_enter: st=%0d, required 0", state);
    end
`endif
  endtask

  // Randomized key stream against a key-level model.
  task automatic test_random();
    int m_state, m_a, m_b, m_op, m_res, m_neg, m_left, m_done;
    int c;
    logic v;
    bit chain;
`ifdef CALC_CHAIN_EN
    chain = 1'b1;
`else
    chain = 1'b0;
`endif
    rst = 1'b1;
    #3;
    @(negedge clk);
    rst = 1'b0;
    m_state = 0; m_a = 0; m_b = 0; m_op = 0; m_res = 0; m_neg = 0; m_left = 0; m_done = 0;
    for (int cyc = 0; cyc < 800; cyc++) begin
      int r;
      v = ($urandom_range(0, 9) < 7);
      r = $urandom_range(0, 99);
      if (r < 50)      c = $urandom_range(0, 9);
      else if (r < 68) c = $urandom_range(10, 12);
      else if (r < 88) c = 13;
      else if (r < 94) c = 14;
      else             c = 15;
      m_done = 0;
      case (m_state)
        0: if (v) begin
          if (c <= 9) m_a = (m_a % 10) * 10 + c;
          else if (c <= 12) begin m_op = c - 10; m_b = 0; m_state = 1; end
          else if (c == 14) begin m_a = 0; m_op = 0; end
        end
        1: if (v) begin
          if (c <= 9) m_b = (m_b % 10) * 10 + c;
          else if (c <= 12) m_op = c - 10;
          else if (c == 13) begin m_state = 2; m_res = 0; m_left = (m_op == 2) ? OPW : 1; end
          else if (c == 14) begin m_a = 0; m_b = 0; m_op = 0; m_res = 0; m_neg = 0; m_state = 0; end
        end
        2: begin
          m_left--;
          if (m_left == 0) begin
            if (m_op == 0)      begin m_res = m_a + m_b; m_neg = 0; end
            else if (m_op == 2) begin m_res = m_a * m_b; m_neg = 0; end
            else if (m_a >= m_b) begin m_res = m_a - m_b; m_neg = 0; end
            else                 begin m_res = m_b - m_a; m_neg = 1; end
            m_state = 3;
            m_done  = 1;
          end
        end
        default: if (v) begin
          if (c <= 9) begin m_a = c; m_b = 0; m_res = 0; m_neg = 0; m_state = 0; end
          else if (c == 14) begin m_a = 0; m_b = 0; m_op = 0; m_res = 0; m_neg = 0; m_state = 0; end
          else if (c <= 12 && chain && m_neg == 0 && m_res <= 99) begin
            m_a = m_res; m_op = c - 10; m_b = 0; m_neg = 0; m_state = 1;
          end
        end
      endcase
      tick(v, 4'(c));
      n_checks++;
      if (int'(state) != m_state || int'(operand_a) != m_a || int'(operand_b) != m_b ||
          int'(op) != m_op || int'(busy) != int'(m_state == 2) || int'(done) != m_done ||
          (m_state != 2 && (int'(result) != m_res || int'(result_neg) != m_neg))) begin
        n_fail++;
        $display("FAIL random cyc %0d: st=%0d a=%0d b=%0d op=%0d res=%0d neg=%0b busy=%0b done=%0b, required st=%0d a=%0d b=%0d op=%0d res=%0d neg=%0d done=%0d",
                 cyc, state, operand_a, operand_b, op, result, result_neg, busy, done,
                 m_state, m_a, m_b, m_op, m_res, m_neg, m_done);
      end
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_clear_opa();
    test_sub();
    test_mul_busy();
    test_reset_mid_mul();
    test_chain();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
